// File: rtl/wi23_defs.sv
// Shared definitions for the multiply/divide unit and the ALU it borrows.
package wi23_defs;

    localparam int REGFILE_WIDTH = 32;

    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_RSUB = 4'b1111;

    typedef enum logic [1:0] {
        MUL   = 2'b00,
        MULHU = 2'b01,
        DIVU  = 2'b10,
        REMU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mdu_seq.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-divide
// step per granted cycle on the shared external ALU.
module mdu_seq
    import wi23_defs::*;
#(
    parameter int W = REGFILE_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [1:0]   op_i,
    input  logic [W-1:0] rs_a,
    input  logic [W-1:0] rs_b,
    output logic         alu_req,
    input  logic         alu_gnt,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         div_by_zero
);

    localparam logic [5:0] LAST_ITER = 6'(W - 1);

    mdu_state_t   state;
    mdu_op_t      op_q;
    logic [5:0]   cnt;
    logic [W-1:0] oper_q;   // multiplicand or divisor
    logic [W-1:0] hi_q;     // product high word / remainder
    logic [W-1:0] lo_q;     // product low word / dividend shifting out, quotient shifting in

    logic [W-1:0] hi_nxt;
    logic [W-1:0] lo_nxt;
    logic [W:0]   rem33;
    logic         carry;
    logic         ge;

    function automatic logic add_carry(input logic [W-1:0] sum, input logic [W-1:0] addend);
        return sum < addend;
    endfunction

    function automatic logic rem_ge(input logic [W:0] rem, input logic [W-1:0] divisor);
        return rem >= {1'b0, divisor};
    endfunction

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_OP_ADD;
        rem33  = {hi_q, lo_q[W-1]};
        hi_nxt = hi_q;
        lo_nxt = lo_q;
        carry  = 1'b0;
        ge     = 1'b0;
        if (state == RUN) begin
            if (!op_q[1]) begin
                alu_a = hi_q;
                alu_b = oper_q;
                carry = add_carry(alu_out, hi_q);
                if (lo_q[0])
                    {hi_nxt, lo_nxt} = {carry, alu_out, lo_q[W-1:1]};
                else
                    {hi_nxt, lo_nxt} = {1'b0, hi_q, lo_q[W-1:1]};
            end else begin
                alu_op = ALU_OP_RSUB;
                alu_a  = oper_q;
                alu_b  = rem33[W-1:0];
                ge     = rem_ge(rem33, oper_q);
                hi_nxt = ge ? alu_out : rem33[W-1:0];
                lo_nxt = {lo_q[W-2:0], ge};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= MUL;
            cnt         <= '0;
            oper_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            div_by_zero <= 1'b0;
            alu_req     <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        op_q        <= mdu_op_t'(op_i);
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        hi_q        <= '0;
                        lo_q        <= op_i[1] ? rs_a : rs_b;
                        oper_q      <= op_i[1] ? rs_b : rs_a;
                        // Divide by zero never touches the ALU.
                        if (op_i[1] && rs_b == '0) begin
                            state       <= DONE;
                            res_valid   <= 1'b1;
                            div_by_zero <= 1'b1;
                            res_data    <= op_i[0] ? rs_a : '1;
                        end else begin
                            state   <= RUN;
                            alu_req <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (alu_gnt) begin
                        hi_q <= hi_nxt;
                        lo_q <= lo_nxt;
                        if (cnt == LAST_ITER) begin
                            state       <= DONE;
                            alu_req     <= 1'b0;
                            res_valid   <= 1'b1;
                            div_by_zero <= 1'b0;
                            res_data    <= op_q[0] ? hi_nxt : lo_nxt;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    res_valid   <= 1'b0;
                    alu_req     <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
